// File: rtl/jtag_host_driver.sv
// JTAG initiator: runs one TAP reset / IR scan / DR scan / idle command at a time,
// generating TCK cells of 2*CLK_DIV clocks and returning captured TDO bits.
module jtag_host_driver #(
  parameter int CLK_DIV = 16,
  parameter int MAX_LEN = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [6:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               jtag_clk,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  input  logic               jtag_tdo
);
  localparam int CW  = $clog2(2*CLK_DIV);
  localparam int BCW = $clog2(MAX_LEN+7);
  localparam logic [CW-1:0] RISE = CW'(CLK_DIV-1);
  localparam logic [CW-1:0] FALL = CW'(2*CLK_DIV-1);

  typedef enum logic [2:0] {IDLE, TMS_SEQ, SHIFT, TMS_POST, DONE} state_t;

  state_t             state_q, state_n;
  logic [CW-1:0]      cnt_q;
  logic [BCW-1:0]     bit_q, bit_n;
  logic [1:0]         typ_q;
  logic [BCW-1:0]     len_q;
  logic [MAX_LEN-1:0] data_q, mask_q, acc_q;
  logic [BCW-1:0]     pre_n;
  logic [7:0]         pre_pat;
  logic               pre_bit, accept, active, cell_end;
  logic               ld, ld_tms, ld_tdi, sh_ld;

  assign cmd_ready = (state_q == IDLE) || (state_q == DONE);
  assign busy      = !cmd_ready;
  assign rsp_valid = (state_q == DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign active    = (state_q == TMS_SEQ) || (state_q == SHIFT) || (state_q == TMS_POST);
  assign cell_end  = (cnt_q == FALL);

  // Leading TMS cells per command type, LSB first; idle cycles reuse this segment with TMS=0.
  always_comb begin
    pre_n   = '0;
    pre_pat = 8'h00;
    case (typ_q)
      2'd0: begin pre_n = BCW'(6);                       pre_pat = 8'h1F; end
      2'd1: begin pre_n = (len_q == '0) ? '0 : BCW'(4);  pre_pat = 8'h03; end
      2'd2: begin pre_n = (len_q == '0) ? '0 : BCW'(3);  pre_pat = 8'h01; end
      default: begin pre_n = len_q;                      pre_pat = 8'h00; end
    endcase
    pre_bit = (int'(bit_q) < 8) ? pre_pat[bit_q[2:0]] : 1'b0;
  end

  // Next-state and next-cell selection; cells are only loaded on a cell boundary.
  always_comb begin
    state_n = state_q;
    bit_n   = bit_q;
    ld      = 1'b0;
    ld_tms  = jtag_tms;
    ld_tdi  = 1'b0;
    sh_ld   = 1'b0;
    case (state_q)
      IDLE, DONE: state_n = accept ? TMS_SEQ : IDLE;
      TMS_SEQ: if (cell_end) begin
        if (bit_q < pre_n) begin
          ld = 1'b1; ld_tms = pre_bit; bit_n = bit_q + BCW'(1);
        end else if (typ_q[1] != typ_q[0] && len_q != '0) begin
          state_n = SHIFT; ld = 1'b1; sh_ld = 1'b1;
          ld_tdi = data_q[0]; ld_tms = (len_q == BCW'(1)); bit_n = BCW'(1);
        end else begin
          state_n = DONE;
        end
      end
      SHIFT: if (cell_end) begin
        if (bit_q < len_q) begin
          ld = 1'b1; sh_ld = 1'b1;
          ld_tdi = data_q[0]; ld_tms = (bit_q == len_q - BCW'(1)); bit_n = bit_q + BCW'(1);
        end else begin
          state_n = TMS_POST; ld = 1'b1; ld_tms = 1'b1; bit_n = BCW'(1);
        end
      end
      TMS_POST: if (cell_end) begin
        if (bit_q < BCW'(2)) begin
          ld = 1'b1; ld_tms = 1'b0; bit_n = bit_q + BCW'(1);
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      typ_q    <= '0;
      len_q    <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      acc_q    <= '0;
      rsp_data <= '0;
      jtag_clk <= 1'b0;
      jtag_tms <= 1'b1;
      jtag_tdi <= 1'b0;
    end else begin
      state_q <= state_n;
      if (accept) begin
        typ_q  <= cmd_type;
        len_q  <= (int'(cmd_len) > MAX_LEN) ? BCW'(MAX_LEN) : BCW'(cmd_len);
        data_q <= cmd_data;
        mask_q <= '0;
        acc_q  <= '0;
        bit_q  <= '0;
        // Start on a boundary so the first cell is loaded on the next edge.
        cnt_q  <= FALL;
      end else if (active) begin
        if (cell_end) begin
          cnt_q    <= '0;
          jtag_clk <= 1'b0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == RISE) begin
            jtag_clk <= 1'b1;
            if (state_q == SHIFT) acc_q <= acc_q | (mask_q & {MAX_LEN{jtag_tdo}});
          end
        end
        bit_q <= bit_n;
        if (ld) begin
          jtag_tms <= ld_tms;
          jtag_tdi <= ld_tdi;
        end
        if (sh_ld) begin
          data_q <= data_q >> 1;
          mask_q <= (mask_q == '0) ? MAX_LEN'(1) : (mask_q << 1);
        end
        if (state_n == DONE) rsp_data <= acc_q;
      end
    end
  end
endmodule

// File: doc/jtag_host_driver.md
Name: jtag_host_driver

Overview:
- Clocked JTAG initiator that drives TCK/TMS/TDI and samples TDO toward a JTAG TAP target, such as the on-chip debug TAP.
- Executes one command at a time from a valid/ready command port: TAP reset, IR scan, DR scan, or run-test idle cycles.
- Returns captured TDO bits on a single-cycle response strobe.
- Used for on-board self-test of the debug path and as the host side in loopback benches.

Parameters:
- CLK_DIV, 16: clk cycles per TCK half-period (≥1). Must exceed the target's TCK input filter/debounce time.
- MAX_LEN, 64: maximum shift length in bits; sets the cmd_data/rsp_data width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_type  input  2  0=TAP reset, 1=IR scan, 2=DR scan, 3=idle cycles
- cmd_len  input  7  bits to shift (types 1/2) or TCK count (type 3)
- cmd_data  input  MAX_LEN  TDI bits, LSB shifted first
- rsp_valid  output  1  one-cycle pulse, command complete
- rsp_data  output  MAX_LEN  captured TDO bits, right-aligned
- busy  output  1  command in progress
- jtag_clk  output  1  TCK
- jtag_tms  output  1  TMS
- jtag_tdi  output  1  TDI
- jtag_tdo  input  1  TDO

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on posedge clk.
- Reset values: jtag_clk=0, jtag_tms=1, jtag_tdi=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, state=IDLE.
- TAP state after reset is unknown. Software must issue a type 0 command first.
- Handshake:
  - A command is accepted on the posedge where cmd_valid && cmd_ready. cmd_type, cmd_len and cmd_data are latched on that edge.
  - cmd_ready=0 and busy=1 from the next cycle until completion. cmd_valid while busy is ignored.
- TCK bit cell, 2*CLK_DIV clk cycles:
  - TMS/TDI are updated at cell start while TCK=0.
  - TCK rises after CLK_DIV cycles. TDO is sampled on the clk edge that raises TCK.
  - TCK falls after a further CLK_DIV cycles, ending the cell.
  - TCK idles low.
- States: IDLE, TMS_SEQ, SHIFT, TMS_POST, DONE.
- TMS sequences (each TMS value is one TCK cell; all scans start and end in Run-Test/Idle):
  - Type 0 (reset): TMS = 1,1,1,1,1,0 → 6 cells.
  - Type 1 (IR scan): pre 1,1,0,0; shift N cells; post 1,0 → N+6 cells.
  - Type 2 (DR scan): pre 1,0,0; shift N cells; post 1,0 → N+5 cells.
  - Type 3 (idle): N cells, TMS=0, TDI=0.
- SHIFT state:
  - Cell i (0..N-1) drives TDI=cmd_data[i] and captures TDO into rsp_data[i].
  - TMS=0 for cells 0..N-2 and TMS=1 on cell N-1 (Exit1). Post sequence is then TMS=1 (Update), TMS=0 (RTI).
  - rsp_data bits ≥ N are 0.
  - TDI=0 outside SHIFT.
- DONE: the cycle after the last TCK fall. rsp_valid=1 for exactly one cycle, cmd_ready=1, busy=0 in the same cycle. rsp_data holds its value until the next rsp_valid.
- Latency from the accept edge to rsp_valid: cells*2*CLK_DIV + 1 clk cycles.
- Length rules:
  - cmd_len>MAX_LEN is clamped to MAX_LEN.
  - cmd_len=0 with type 1/2/3: no TCK activity, rsp_valid on the 2nd cycle after accept, rsp_data=0.
  - cmd_len is ignored for type 0.
- Reset mid-command: outputs take their reset values on that edge and the response is lost. The target TAP is then in an undefined state.
- The half-period counter and bit counter must not wrap during a cell. The bit counter width is ≥ clog2(MAX_LEN+7).

Test Plan:
- CLK_DIV=2, reset, then type 0 → 6 TCK pulses with TMS=1,1,1,1,1,0 sampled at TCK rises; rsp_valid exactly 25 cycles after accept; TDI stays 0.
- IR scan, len=5, data=0x11, TDO tied to a 5-bit TAP model preloaded with 0x01 → TMS pattern 1,1,0,0,0,0,0,0,1,1,0; TDI bits 1,0,0,0,1; rsp_data=0x01; TAP model IR=0x11.
- DR scan, len=41, data=0x1_2345_6789 looped TDI→TDO through a 1-cycle-delayed flop model → rsp_data equals the expected shifted pattern; 46 TCK pulses; rsp_data[63:41]=0.
- cmd_len=0 DR scan → no TCK edge, rsp_valid 2 cycles after accept, rsp_data=0. cmd_len=100 → exactly 64 shift cells.
- cmd_valid held high through a scan with different data → second command accepted only in the rsp_valid cycle. Back-to-back commands produce no TCK glitch; TMS stays 0 between them.
- rst_n low mid-SHIFT for 1 cycle → next edge: jtag_clk=0, jtag_tms=1, cmd_ready=1, no rsp_valid.
